// File: rtl/myproject_mac_pkg.sv
// Shared constants and the saturating narrow helper for the MAC pipeline.
package myproject_mac_pkg;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Clamp a sign-extended value into the signed range of a w-bit word (w <= 64).
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                      input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/myproject_mac_pipe_if.sv
// Beat/result bundle between the feature streams and the MAC pipeline.
interface myproject_mac_pipe_if #(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 24
);
    logic                         ce;
    logic                         in_valid;
    logic                         in_first;
    logic                         in_last;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         ovf;

    modport master (
        output ce, in_valid, in_first, in_last, din0, din1,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  ce, in_valid, in_first, in_last, din0, din1,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/myproject_mac_pipe_mult.sv
// Pipelined signed multiplier with a valid/first/last sideband riding alongside the product.
module myproject_mac_pipe_mult #(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 16,
    parameter int NUM_STAGE  = 3
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst,
    input  logic                                    ce_i,
    input  logic                                    valid_i,
    input  logic                                    first_i,
    input  logic                                    last_i,
    input  logic signed [DIN0_WIDTH-1:0]            a_i,
    input  logic signed [DIN1_WIDTH-1:0]            b_i,
    output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] p_o,
    output logic                                    valid_o,
    output logic                                    first_o,
    output logic                                    last_o
);
    localparam int P_W = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] p_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]  vld_q;
    logic [NUM_STAGE-1:0]  first_q;
    logic [NUM_STAGE-1:0]  last_q;

    assign prod = a_i * b_i;

    // Only the valid chain is reset; product and markers are qualified by it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q <= '0;
        end else if (ce_i) begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ce_i) begin
            p_q[0]     <= prod;
            first_q[0] <= first_i;
            last_q[0]  <= last_i;
            for (int i = 1; i < NUM_STAGE; i++) begin
                p_q[i]     <= p_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign p_o     = p_q[NUM_STAGE-1];
    assign valid_o = vld_q[NUM_STAGE-1];
    assign first_o = first_q[NUM_STAGE-1];
    assign last_o  = last_q[NUM_STAGE-1];
endmodule

// File: rtl/myproject_mac_pipe.sv
// Grouped signed multiply-accumulate: multiplier pipe, accumulate stage, narrow/output stage.
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 13,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 24,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_STAGE  = 3,
    parameter int SAT_MODE   = SAT_WRAP,
    parameter int FRAC_SHIFT = 0
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    myproject_mac_pipe_if.slave bus
);
    localparam int P_W = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [P_W-1:0]        m_p;
    logic                         m_vld, m_first, m_last;
    logic signed [ACC_WIDTH-1:0]  p_ext, sum, acc_q, acc_d, res_q, shifted;
    logic                         grp_q, grp_d, add_ovf;
    logic                         res_vld_q, res_ovf_q;
    logic signed [63:0]           ext, sat;
    logic                         clamp;
    logic signed [DOUT_WIDTH-1:0] narrow_d, dout_q;
    logic                         out_valid_q, ovf_q;

    myproject_mac_pipe_mult #(
        .DIN0_WIDTH(DIN0_WIDTH),
        .DIN1_WIDTH(DIN1_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mult (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .ce_i   (bus.ce),
        .valid_i(bus.in_valid),
        .first_i(bus.in_first),
        .last_i (bus.in_last),
        .a_i    (bus.din0),
        .b_i    (bus.din1),
        .p_o    (m_p),
        .valid_o(m_vld),
        .first_o(m_first),
        .last_o (m_last)
    );

    // Accumulate stage: overflow is a same-sign add producing a flipped sign.
    always_comb begin
        p_ext   = ACC_WIDTH'(m_p);
        sum     = acc_q + p_ext;
        add_ovf = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        acc_d   = m_first ? p_ext : sum;
        grp_d   = m_first ? 1'b0 : (grp_q | add_ovf);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q     <= '0;
            grp_q     <= 1'b0;
            res_vld_q <= 1'b0;
        end else if (bus.ce) begin
            res_vld_q <= m_vld && m_last;
            if (m_vld) begin
                acc_q <= m_last ? '0 : acc_d;
                grp_q <= m_last ? 1'b0 : grp_d;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (bus.ce && m_vld && m_last) begin
            res_q     <= acc_d;
            res_ovf_q <= grp_d;
        end
    end

    // Output stage: narrowing is kept off the accumulator add path.
    always_comb begin
        shifted  = res_q >>> FRAC_SHIFT;
        ext      = 64'(shifted);
        sat      = sat_narrow(ext, DOUT_WIDTH);
        clamp    = (SAT_MODE == SAT_CLAMP) && (sat != ext);
        narrow_d = (SAT_MODE == SAT_CLAMP) ? DOUT_WIDTH'(sat) : DOUT_WIDTH'(ext);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (bus.ce) begin
            out_valid_q <= res_vld_q;
            if (res_vld_q) begin
                dout_q <= narrow_d;
                ovf_q  <= res_ovf_q | clamp;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/myproject_mac_pipe.md
# myproject_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the generated GNN datapath. It supersedes the fixed-width combinational multiplier primitives. Features: configurable operand and result widths, a configurable multiplier pipeline depth, group accumulation with first/last markers, selectable wrap or saturate output narrowing, and clock-enable stall. It sits between the edge/node feature streams and the aggregation logic, producing one dot-product result per marked group.

## Interface
- DIN0_WIDTH, 13, signed width of din0
- DIN1_WIDTH, 16, signed width of din1
- DOUT_WIDTH, 24, signed width of dout
- ACC_WIDTH, 40, accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH
- NUM_STAGE, 3, multiplier pipeline registers, legal range 1..4
- SAT_MODE, 0, output narrowing: 0 = keep low DOUT_WIDTH bits, 1 = saturate
- FRAC_SHIFT, 0, arithmetic right shift applied to the accumulator before narrowing, range 0..ACC_WIDTH-1

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; 0 freezes every register
- in_valid  in  1  din0/din1 carry a valid beat
- in_first  in  1  beat starts a new group (acc loaded, not added)
- in_last  in  1  beat ends the group (result emitted)
- din0  in  DIN0_WIDTH  signed operand
- din1  in  DIN1_WIDTH  signed operand
- out_valid  out  1  dout holds a new group result
- dout  out  DOUT_WIDTH  signed group result
- ovf  out  1  group overflowed (accumulator wrap or saturation clamp)

## Operation
- Product p = din0 × din1, full DIN0_WIDTH+DIN1_WIDTH bits, no truncation; sign-extended to ACC_WIDTH.
- valid/first/last travel in a shift register alongside p through NUM_STAGE registers.
- Accumulate stage, on product valid: acc_next = first ? p : acc + p (wraps at ACC_WIDTH). Group overflow flag is set on signed add overflow and is cleared on first.
- On product valid with last:
  - dout ← narrow(acc_next >>> FRAC_SHIFT); out_valid ← 1; ovf ← group flag OR clamp.
  - acc resets to 0 and the flag clears, so a following beat missing first starts a fresh group.
- narrow: SAT_MODE 0 takes the low DOUT_WIDTH bits (no flag from truncation). SAT_MODE 1 clamps to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1].
- first and last on the same beat: single-product result.
- Non-valid beats: first/last are ignored.
- dout and ovf hold their last value until the next result. out_valid is 0 on every other enabled cycle.
- ap_rst: clears pipeline valids, acc, group flag, dout=0, out_valid=0, ovf=0. Groups in flight are discarded; ap_rst overrides ce.

## Timing
- Latency: beat accepted at edge t (ce=1) → out_valid/dout visible after edge t+NUM_STAGE+1.
- Throughput: one beat per enabled cycle. Back-to-back groups (last followed immediately by first) are legal with no bubble.
- ce=0: all state holds, including out_valid. Consumers qualify out_valid with ce. Each stalled cycle adds one cycle of latency.
- No combinational path from inputs to outputs.

## Structure
- Package myproject_mac_pkg: SAT_WRAP=0 and SAT_CLAMP=1 constants; saturating-narrow function parametrised by widths.
- Sub-module myproject_mac_pipe_mult: pipelined signed multiplier (NUM_STAGE registers with ce and sideband shift register), suitable for DSP inference. The accumulator and narrowing logic live in the top.

## Test plan
- Single beat, NUM_STAGE=3, first=last=1, din0=−3, din1=1000 at edge t → out_valid at t+4, dout=24'hFFF448 (−3000), ovf=0.
- 4-beat group (2,3),(−4,5),(100,−7),(1,1) → single out_valid, dout=−713. Repeat with FRAC_SHIFT=2 → dout=−179.
- Four beats of 4095×32767:
  - SAT_MODE=1 → dout=24'h7FFFFF, ovf=1.
  - SAT_MODE=0 → dout=24'hFDC004, ovf=0.
- ce low 2 cycles mid-group → same result as the 4-beat group (−713), out_valid 2 cycles later, no duplicate pulse.
- ap_rst after 2 beats of a group, then single beat 5×6 → dout=30, no residue; all outputs 0 during reset.
- Back-to-back groups {(1,2),(3,4)} then {(−1,−1)} with no gap → out_valid on two consecutive-group cycles, dout=14 then 1.
